branch_ldi_sequencer: RTL and testbench
=======================================

Name: branch_ldi_sequencer

Overview:
- Hardwired control-step sequencer for the datapath. It generates the per-cycle control strobes for the instruction fetch (T0–T2).
- It then executes either ldi, or the conditional branch family brzr/brnz/brpl/brmi (opcode 10011), in the execute steps.
- It replaces hand-driven bench control sequences and adds three things: a memory-wait handshake with timeout, trap on illegal opcode, and retired/taken counters.
- It sits between the IR field outputs and the datapath control inputs.

Parameters:
- OPC_WIDTH, 5, opcode field width (IR[31:27]).
- ALU_ADD, 5'b00011, ALU opcode driven for address/immediate add.
- OPC_LDI, 5'b00001, ldi opcode.
- OPC_BR, 5'b10011, branch opcode.
- MEM_TIMEOUT, 8, maximum T1 wait cycles before a memory fault.
- CNT_WIDTH, 16, width of the instruction and taken-branch counters.

Ports:
- Clock  in  1  system clock, rising edge.
- clear  in  1  asynchronous, active-low reset.
- run  in  1  level; while high, the sequencer fetches continuously.
- ir_opcode  in  OPC_WIDTH  IR[31:27], valid from T3.
- memory_done  in  1  memory read data is valid this cycle.
- con_ff_bit  in  1  CON flip-flop output, latched in T3.
- PCout, IncPC, MARin, Zin, Zlo_out, PCin, MDRin, Mem_Read, Mem_enable512x32, MDRout, IRin, Gra, Grb, Rin, Rout, BAout, Yin, Cout, CONin  out  1 each  datapath strobes.
- opcode  out  OPC_WIDTH  ALU operation select.
- busy  out  1  high in any state other than IDLE or TRAP.
- branch_taken  out  1  one-cycle pulse when a branch loads PC.
- trap  out  1  high in TRAP.
- fault_code  out  2  00 none, 01 illegal opcode, 10 memory timeout.
- instr_count  out  CNT_WIDTH  instructions retired.
- taken_count  out  CNT_WIDTH  branches taken.

Behaviour:
- Reset (clear=0, async): state=IDLE. All strobes, busy, branch_taken and trap are 0. opcode=0, fault_code=00, both counters=0.
- Strobes are registered Moore outputs decoded from the state, glitch-free. Exactly one state is active per cycle.
- IDLE: if run=1, go to T0 next edge; otherwise stay.
- T0: PCout, IncPC, MARin, Zin; opcode=ALU_ADD.
- T1: Zlo_out, PCin, MDRin, Mem_Read, Mem_enable512x32, all held for the whole wait.
  - Re-loading PC from an unchanged Z is idempotent.
  - Leave to T2 on the edge where memory_done=1.
  - On the MEM_TIMEOUT-th cycle without memory_done, go to TRAP with fault 10.
  - The wait counter clears on T1 entry.
- T2: MDRout, IRin.
- T3 decode on ir_opcode:
  - OPC_LDI: Grb, BAout, Yin; go to L4.
  - OPC_BR: Gra, Rout, CONin; go to B4.
  - Anything else: go to TRAP with fault 01; no strobes in that cycle.
- L4: Cout, Zin, opcode=ALU_ADD. Then L5: Zlo_out, Gra, Rin; instruction retires.
- B4: PCout, Yin. Then B5: Cout, Zin, opcode=ALU_ADD.
- B6: Zlo_out always. PCin only if con_ff_bit=1 in that cycle.
  - If taken: branch_taken=1 for that cycle and taken_count increments.
  - Instruction retires whether or not the branch is taken.
- Retire (L5 or B6): instr_count increments. Next state is T0 if run=1, else IDLE.
- Both counters wrap modulo 2^CNT_WIDTH.
- run only takes effect at IDLE and at the retire cycle. Dropping run mid-instruction completes the instruction.
- TRAP: all strobes are 0 and trap=1; it is sticky. Only clear exits TRAP; run is ignored there.
- clear asserted mid-instruction: immediate return to IDLE with all strobes deasserted. Counters and fault_code reset.
- Latency: ldi = 6 cycles + memory wait; branch = 7 cycles + memory wait. Minimum memory wait is 0 (memory_done already high in the first T1 cycle).

Decomposition:
- Shared package seq_pkg holds:
  - the state enum (IDLE, T0, T1, T2, T3, L4, L5, B4, B5, B6, TRAP);
  - the opcode constants (OPC_LDI, OPC_BR, ALU_ADD);
  - the fault_code encodings.
- One sub-module, seq_event_counters: the instr_count and taken_count saturating-free wrap counters with increment enables.
- The FSM and output decode stay in the top module.

Test Plan:
- ldi r5,0 with memory_done high in the first T1, run=1 → strobe sequence T0,T1,T2,T3(Grb,BAout,Yin),L4(Cout,Zin,opcode=00011),L5(Zlo_out,Gra,Rin). instr_count=1, then T0 again.
- brzr with con_ff_bit=1 at B6 → PCin=1 and branch_taken pulse in B6 only; taken_count=1. Repeat with con_ff_bit=0 → PCin=0 in B6, taken_count unchanged, instr_count increments.
- memory_done delayed 3 cycles → T1 lasts 4 cycles with MDRin/Mem_Read held; instruction still completes, ldi total = 9 cycles.
- memory_done never asserted, MEM_TIMEOUT=8 → TRAP after 8 T1 cycles, fault_code=10, strobes 0. run toggling has no effect; clear pulse returns to IDLE with counters 0.
- ir_opcode=5'b11111 at T3 → TRAP, fault_code=01, instr_count unchanged.
- run dropped during B5 → B6 completes, then IDLE. Plus a clear asserted mid-T2 → all strobes 0 asynchronously, before the next edge.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and constants for the ldi/branch control-step sequencer.
package seq_pkg;

  localparam logic [4:0] ALU_ADD = 5'b00011;
  localparam logic [4:0] OPC_LDI = 5'b00001;
  localparam logic [4:0] OPC_BR  = 5'b10011;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  typedef enum logic [3:0] {
    IDLE, T0, T1, T2, T3, L4, L5, B4, B5, B6, TRAP
  } state_t;

  // Strobes that depend on the state alone. Grb, Rout, BAout, CONin and the
  // conditional PCin of B6 also depend on live inputs and are added in the top.
  typedef struct packed {
    logic pc_out;
    logic inc_pc;
    logic mar_in;
    logic z_in;
    logic zlo_out;
    logic pc_in;
    logic mdr_in;
    logic mem_read;
    logic mem_en;
    logic mdr_out;
    logic ir_in;
    logic gra;
    logic rin;
    logic yin;
    logic cout;
  } strobes_t;

  function automatic strobes_t decode_strobes(state_t s);
    strobes_t d;
    d = '0;
    case (s)
      T0: begin d.pc_out = 1'b1; d.inc_pc = 1'b1; d.mar_in = 1'b1; d.z_in = 1'b1; end
      T1: begin
        d.zlo_out = 1'b1; d.pc_in = 1'b1; d.mdr_in = 1'b1;
        d.mem_read = 1'b1; d.mem_en = 1'b1;
      end
      T2: begin d.mdr_out = 1'b1; d.ir_in = 1'b1; end
      L4: begin d.cout = 1'b1; d.z_in = 1'b1; end
      L5: begin d.zlo_out = 1'b1; d.gra = 1'b1; d.rin = 1'b1; end
      B4: begin d.pc_out = 1'b1; d.yin = 1'b1; end
      B5: begin d.cout = 1'b1; d.z_in = 1'b1; end
      B6: begin d.zlo_out = 1'b1; end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seq_event_counters.sv
// Retired-instruction and taken-branch event counters; both wrap freely.
module seq_event_counters #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 instr_inc,
  input  logic                 taken_inc,
  output logic [CNT_WIDTH-1:0] instr_count,
  output logic [CNT_WIDTH-1:0] taken_count
);

  // Count one retired instruction per enabled cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         instr_count <= '0;
    else if (instr_inc) instr_count <= instr_count + 1'b1;
  end

  // Count one taken branch per enabled cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         taken_count <= '0;
    else if (taken_inc) taken_count <= taken_count + 1'b1;
  end

endmodule

// File: rtl/branch_ldi_sequencer.sv
// Hardwired fetch/execute control-step sequencer for ldi and the brxx family,
// with a memory-wait timeout, illegal-opcode trap and event counters.
module branch_ldi_sequencer
  import seq_pkg::*;
#(
  parameter int OPC_WIDTH   = 5,
  parameter int MEM_TIMEOUT = 8,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 Clock,
  input  logic                 clear,
  input  logic                 run,
  input  logic [OPC_WIDTH-1:0] ir_opcode,
  input  logic                 memory_done,
  input  logic                 con_ff_bit,
  output logic                 PCout,
  output logic                 IncPC,
  output logic                 MARin,
  output logic                 Zin,
  output logic                 Zlo_out,
  output logic                 PCin,
  output logic                 MDRin,
  output logic                 Mem_Read,
  output logic                 Mem_enable512x32,
  output logic                 MDRout,
  output logic                 IRin,
  output logic                 Gra,
  output logic                 Grb,
  output logic                 Rin,
  output logic                 Rout,
  output logic                 BAout,
  output logic                 Yin,
  output logic                 Cout,
  output logic                 CONin,
  output logic [OPC_WIDTH-1:0] opcode,
  output logic                 busy,
  output logic                 branch_taken,
  output logic                 trap,
  output logic [1:0]           fault_code,
  output logic [CNT_WIDTH-1:0] instr_count,
  output logic [CNT_WIDTH-1:0] taken_count
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT) + 1;

  state_t              state, state_next;
  logic [1:0]          fault_next;
  logic [WAIT_W-1:0]   wait_cnt;
  strobes_t            stb_reg;
  logic                is_ldi, is_br, t3_ldi, t3_br, b6_taken, retire;

  assign is_ldi   = (ir_opcode == OPC_WIDTH'(OPC_LDI));
  assign is_br    = (ir_opcode == OPC_WIDTH'(OPC_BR));
  // The IR is only valid from T3, so decode strobes there come straight from it.
  assign t3_ldi   = (state == T3) && is_ldi;
  assign t3_br    = (state == T3) && is_br;
  // CON was latched in T3, so it is stable by B6 and gates PCin directly.
  assign b6_taken = (state == B6) && con_ff_bit;
  assign retire   = (state == L5) || (state == B6);

  // Next-state selection, including trap entry and its fault code.
  always_comb begin
    state_next = state;
    fault_next = fault_code;
    case (state)
      IDLE: if (run) state_next = T0;
      T0:   state_next = T1;
      T1: begin
        if (memory_done) begin
          state_next = T2;
        end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
          state_next = TRAP;
          fault_next = FAULT_TIMEOUT;
        end
      end
      T2:   state_next = T3;
      T3: begin
        if (is_ldi)     state_next = L4;
        else if (is_br) state_next = B4;
        else begin
          state_next = TRAP;
          fault_next = FAULT_ILLEGAL;
        end
      end
      L4:   state_next = L5;
      L5:   state_next = run ? T0 : IDLE;
      B4:   state_next = B5;
      B5:   state_next = B6;
      B6:   state_next = run ? T0 : IDLE;
      TRAP: state_next = TRAP;
      default: state_next = IDLE;
    endcase
  end

  // State register plus outputs pre-decoded from the next state so they are glitch-free.
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      stb_reg    <= '0;
      opcode     <= '0;
      busy       <= 1'b0;
      trap       <= 1'b0;
      fault_code <= FAULT_NONE;
    end else begin
      state      <= state_next;
      fault_code <= fault_next;
      wait_cnt   <= (state == T1 && state_next == T1) ? wait_cnt + 1'b1 : '0;
      stb_reg    <= decode_strobes(state_next);
      opcode     <= (state_next inside {T0, L4, B5}) ? OPC_WIDTH'(ALU_ADD) : '0;
      busy       <= !(state_next inside {IDLE, TRAP});
      trap       <= (state_next == TRAP);
    end
  end

  assign PCout            = stb_reg.pc_out;
  assign IncPC            = stb_reg.inc_pc;
  assign MARin            = stb_reg.mar_in;
  assign Zin              = stb_reg.z_in;
  assign Zlo_out          = stb_reg.zlo_out;
  assign PCin             = stb_reg.pc_in | b6_taken;
  assign MDRin            = stb_reg.mdr_in;
  assign Mem_Read         = stb_reg.mem_read;
  assign Mem_enable512x32 = stb_reg.mem_en;
  assign MDRout           = stb_reg.mdr_out;
  assign IRin             = stb_reg.ir_in;
  assign Gra              = stb_reg.gra | t3_br;
  assign Grb              = t3_ldi;
  assign Rin              = stb_reg.rin;
  assign Rout             = t3_br;
  assign BAout            = t3_ldi;
  assign Yin              = stb_reg.yin | t3_ldi;
  assign Cout             = stb_reg.cout;
  assign CONin            = t3_br;
  assign branch_taken     = b6_taken;

  seq_event_counters #(.CNT_WIDTH(CNT_WIDTH)) u_counters (
    .clk         (Clock),
    .rst_n       (clear),
    .instr_inc   (retire),
    .taken_inc   (b6_taken),
    .instr_count (instr_count),
    .taken_count (taken_count)
  );

endmodule

// File: tb/tb_branch_ldi_sequencer.sv
// Randomized self-checking bench: each instruction is expanded into its
// expected per-cycle control-step list and compared cycle by cycle.
module tb_branch_ldi_sequencer;

  localparam logic [4:0] ADD = 5'b00011;
  localparam logic [4:0] LDI = 5'b00001;
  localparam logic [4:0] BR  = 5'b10011;
  localparam logic [4:0] BAD = 5'b11111;
  localparam int TIMEOUT = 8;

  localparam int I_PCOUT = 0,  I_INCPC = 1,  I_MARIN = 2,  I_ZIN = 3,   I_ZLO = 4;
  localparam int I_PCIN = 5,   I_MDRIN = 6,  I_MEMRD = 7,  I_MEMEN = 8, I_MDROUT = 9;
  localparam int I_IRIN = 10,  I_GRA = 11,   I_GRB = 12,   I_RIN = 13,  I_ROUT = 14;
  localparam int I_BAOUT = 15, I_YIN = 16,   I_COUT = 17,  I_CONIN = 18;

  logic Clock = 0, clear = 1, run = 0, memory_done = 0, con_ff_bit = 0;
  logic [4:0] ir_opcode = '0;
  logic PCout, IncPC, MARin, Zin, Zlo_out, PCin, MDRin, Mem_Read, Mem_enable512x32;
  logic MDRout, IRin, Gra, Grb, Rin, Rout, BAout, Yin, Cout, CONin;
  logic [4:0]  opcode;
  logic        busy, branch_taken, trap;
  logic [1:0]  fault_code;
  logic [15:0] instr_count, taken_count;

  int n_checks = 0, n_fail = 0;
  logic [15:0] exp_instr = '0, exp_taken = '0;

  branch_ldi_sequencer dut (
    .Clock(Clock), .clear(clear), .run(run), .ir_opcode(ir_opcode),
    .memory_done(memory_done), .con_ff_bit(con_ff_bit),
    .PCout(PCout), .IncPC(IncPC), .MARin(MARin), .Zin(Zin), .Zlo_out(Zlo_out),
    .PCin(PCin), .MDRin(MDRin), .Mem_Read(Mem_Read), .Mem_enable512x32(Mem_enable512x32),
    .MDRout(MDRout), .IRin(IRin), .Gra(Gra), .Grb(Grb), .Rin(Rin), .Rout(Rout),
    .BAout(BAout), .Yin(Yin), .Cout(Cout), .CONin(CONin), .opcode(opcode),
    .busy(busy), .branch_taken(branch_taken), .trap(trap), .fault_code(fault_code),
    .instr_count(instr_count), .taken_count(taken_count)
  );

  always #5 Clock = ~Clock;

  logic [18:0] stb_obs;
  logic [28:0] obs;
  assign stb_obs = {CONin, Cout, Yin, BAout, Rout, Rin, Grb, Gra, IRin, MDRout,
                    Mem_enable512x32, Mem_Read, MDRin, PCin, Zlo_out, Zin, MARin, IncPC, PCout};
  assign obs = {stb_obs, opcode, branch_taken, busy, trap, fault_code};

  typedef struct {
    logic [28:0] obs;
    bit t1; bit md; bit opc_live; bit con_live; bit retire; bit taken;
  } step_t;
  step_t steps[$];

  function automatic logic [18:0] sb(int i);
    return 19'(1) << i;
  endfunction

  function automatic logic [28:0] ob(logic [18:0] s, logic [4:0] alu, bit tk, bit bz, bit tr, logic [1:0] f);
    return {s, alu, tk, bz, tr, f};
  endfunction

  function automatic step_t mk(logic [28:0] o, bit t1, bit md, bit ol, bit cl, bit rt, bit tk);
    step_t x;
    x.obs = o; x.t1 = t1; x.md = md; x.opc_live = ol; x.con_live = cl; x.retire = rt; x.taken = tk;
    return x;
  endfunction

  // kind: 0 ldi, 1 branch, 2 illegal. delay < 0 means memory never answers.
  task automatic build(input int kind, input int delay, input bit con);
    logic [18:0] t1s;
    t1s = sb(I_ZLO) | sb(I_PCIN) | sb(I_MDRIN) | sb(I_MEMRD) | sb(I_MEMEN);
    steps.delete();
    steps.push_back(mk(ob(sb(I_PCOUT) | sb(I_INCPC) | sb(I_MARIN) | sb(I_ZIN), ADD, 0, 1, 0, 2'b00), 0, 0, 0, 0, 0, 0));
    if (delay < 0) begin
      for (int j = 0; j < TIMEOUT; j++) steps.push_back(mk(ob(t1s, 5'd0, 0, 1, 0, 2'b00), 1, 0, 0, 0, 0, 0));
      steps.push_back(mk(ob('0, 5'd0, 0, 0, 1, 2'b10), 0, 0, 0, 0, 0, 0));
      return;
    end
    for (int j = 0; j <= delay; j++) steps.push_back(mk(ob(t1s, 5'd0, 0, 1, 0, 2'b00), 1, (j == delay), 0, 0, 0, 0));
    steps.push_back(mk(ob(sb(I_MDROUT) | sb(I_IRIN), 5'd0, 0, 1, 0, 2'b00), 0, 0, 0, 0, 0, 0));
    if (kind == 0) begin
      steps.push_back(mk(ob(sb(I_GRB) | sb(I_BAOUT) | sb(I_YIN), 5'd0, 0, 1, 0, 2'b00), 0, 0, 1, 0, 0, 0));
      steps.push_back(mk(ob(sb(I_COUT) | sb(I_ZIN), ADD, 0, 1, 0, 2'b00), 0, 0, 1, 0, 0, 0));
      steps.push_back(mk(ob(sb(I_ZLO) | sb(I_GRA) | sb(I_RIN), 5'd0, 0, 1, 0, 2'b00), 0, 0, 1, 0, 1, 0));
    end else if (kind == 1) begin
      steps.push_back(mk(ob(sb(I_GRA) | sb(I_ROUT) | sb(I_CONIN), 5'd0, 0, 1, 0, 2'b00), 0, 0, 1, 0, 0, 0));
      steps.push_back(mk(ob(sb(I_PCOUT) | sb(I_YIN), 5'd0, 0, 1, 0, 2'b00), 0, 0, 1, 1, 0, 0));
      steps.push_back(mk(ob(sb(I_COUT) | sb(I_ZIN), ADD, 0, 1, 0, 2'b00), 0, 0, 1, 1, 0, 0));
      steps.push_back(mk(ob(sb(I_ZLO) | (con ? sb(I_PCIN) : 19'd0), 5'd0, con, 1, 0, 2'b00), 0, 0, 1, 1, 1, con));
    end else begin
      steps.push_back(mk(ob('0, 5'd0, 0, 1, 0, 2'b00), 0, 0, 1, 0, 0, 0));
      steps.push_back(mk(ob('0, 5'd0, 0, 0, 1, 2'b01), 0, 0, 1, 0, 0, 0));
    end
  endtask

  // Runs one instruction from T0 entry; drop_at/abort_at are step indices (-1 = never).
  task automatic run_instr(input string nm, input int kind, input logic [4:0] opc, input int delay,
                           input bit con, input int drop_at, input int abort_at);
    build(kind, delay, con);
    $display("txn %s kind=%0d opc=%b delay=%0d con=%0b steps=%0d", nm, kind, opc, delay, con, steps.size());
    for (int i = 0; i < steps.size(); i++) begin
      @(posedge Clock); #1;
      run         = (drop_at < 0) || (i < drop_at);
      memory_done = steps[i].t1 ? steps[i].md : 1'($urandom);
      ir_opcode   = steps[i].opc_live ? opc : 5'($urandom);
      con_ff_bit  = steps[i].con_live ? con : 1'($urandom);
      #1;
      if (i == abort_at) begin
        clear = 0;
        #1;
        exp_instr = '0; exp_taken = '0;
        n_checks++;
        if (obs !== 29'd0 || instr_count !== exp_instr || taken_count !== exp_taken) begin
          n_fail++;
          $display("FAIL %s async_clear step %0d: got obs=%h instr=%0d taken=%0d, want obs=0 counts 0",
                   nm, i, obs, instr_count, taken_count);
        end
        run = 0;
        clear = 1;
        return;
      end
      n_checks++;
      if (obs !== steps[i].obs || instr_count !== exp_instr || taken_count !== exp_taken) begin
        n_fail++;
        $display("FAIL %s step %0d: got obs=%h instr=%0d taken=%0d, want obs=%h instr=%0d taken=%0d",
                 nm, i, obs, instr_count, taken_count, steps[i].obs, exp_instr, exp_taken);
      end
      if (steps[i].retire) exp_instr++;
      if (steps[i].taken)  exp_taken++;
    end
  endtask

  // One IDLE cycle; run_val decides whether the next cycle is T0.
  task automatic idle_step(input bit run_val);
    @(posedge Clock); #1;
    run = run_val;
    memory_done = 1'($urandom);
    ir_opcode = 5'($urandom);
    #1;
    n_checks++;
    if (obs !== 29'd0 || instr_count !== exp_instr || taken_count !== exp_taken) begin
      n_fail++;
      $display("FAIL idle: got obs=%h instr=%0d taken=%0d, want obs=0 instr=%0d taken=%0d",
               obs, instr_count, taken_count, exp_instr, exp_taken);
    end
  endtask

  // TRAP is sticky regardless of run; only clear leaves it and it zeroes the counters.
  task automatic trap_hold(input string nm, input logic [1:0] f);
    for (int k = 0; k < 5; k++) begin
      @(posedge Clock); #1;
      run = 1'($urandom);
      memory_done = 1'($urandom);
      #1;
      n_checks++;
      if (obs !== ob('0, 5'd0, 0, 0, 1, f) || instr_count !== exp_instr || taken_count !== exp_taken) begin
        n_fail++;
        $display("FAIL %s sticky cycle %0d: got obs=%h instr=%0d, want obs=%h instr=%0d",
                 nm, k, obs, instr_count, ob('0, 5'd0, 0, 0, 1, f), exp_instr);
      end
    end
    clear = 0;
    #1;
    exp_instr = '0; exp_taken = '0;
    n_checks++;
    if (obs !== 29'd0 || instr_count !== 16'd0 || taken_count !== 16'd0) begin
      n_fail++;
      $display("FAIL %s clear_exit: got obs=%h instr=%0d taken=%0d, want all 0", nm, obs, instr_count, taken_count);
    end
    run = 0;
    clear = 1;
  endtask

  task automatic test_reset();
    #1 clear = 0;
    @(posedge Clock); #1;
    n_checks++;
    if (obs !== 29'd0 || instr_count !== 16'd0 || taken_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset: got obs=%h instr=%0d taken=%0d, want all 0", obs, instr_count, taken_count);
    end
    #2 clear = 1;
    idle_step(0);
    idle_step(0);
    idle_step(1);
  endtask

  task automatic test_ldi_basic();
    run_instr("ldi_r5_0", 0, LDI, 0, 0, -1, -1);
  endtask

  task automatic test_branch();
    run_instr("brzr_taken", 1, BR, 0, 1, -1, -1);
    run_instr("brzr_not_taken", 1, BR, 1, 0, -1, -1);
  endtask

  task automatic test_mem_wait();
    run_instr("ldi_wait3", 0, LDI, 3, 0, -1, -1);
  endtask

  task automatic test_run_drop();
    run_instr("br_drop_b5", 1, BR, 2, 1, 2 + 5, -1);
    idle_step(0);
    idle_step(1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      int kind, d, last;
      bit con, drop;
      kind = int'($urandom_range(0, 1));
      d    = int'($urandom_range(0, 4));
      con  = 1'($urandom);
      drop = ($urandom_range(0, 4) == 0);
      last = (kind == 1) ? d + 6 : d + 5;
      run_instr("random", kind, (kind == 1) ? BR : LDI, d, con, drop ? last : -1, -1);
      if (drop) begin
        idle_step(0);
        idle_step(1);
      end
    end
  endtask

  task automatic test_illegal();
    run_instr("illegal_11111", 2, BAD, 1, 0, -1, -1);
    trap_hold("illegal", 2'b01);
    idle_step(1);
  endtask

  task automatic test_timeout();
    run_instr("ldi_timeout", 0, LDI, -1, 0, -1, -1);
    trap_hold("timeout", 2'b10);
    idle_step(1);
  endtask

  task automatic test_back_to_back();
    run_instr("b2b_ldi", 0, LDI, 0, 0, -1, -1);
    run_instr("b2b_br", 1, BR, 0, 1, -1, -1);
  endtask

  task automatic test_clear_mid();
    run_instr("ldi_clear_t2", 0, LDI, 1, 0, -1, 3);
    idle_step(0);
  endtask

  initial begin
    test_reset();
    test_ldi_basic();
    test_branch();
    test_mem_wait();
    test_back_to_back();
    test_run_drop();
    test_random();
    test_illegal();
    test_timeout();
    test_clear_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
